digit_glyph_rd: RTL
===================

DIGIT_GLYPH_RD -- requirements
Module: digit_glyph_rd

Interface
REQ-001 The block SHALL have parameter X_OFF, default 0, giving the matrix column of glyph column 0 (legal 0..27).
REQ-002 The block SHALL have parameter Y_OFF, default 0, giving the matrix row of glyph row 0 (legal 0..9).
REQ-003 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1: rising-edge clock for all state.
REQ-005 Port rst, input, 1: asynchronous active-low reset.
REQ-006 Port digit_valid, input, 1: a digit is offered on digit.
REQ-007 Port digit, input, 4: BCD digit to render.
REQ-008 Port digit_ready, output, 1: block can accept a digit.
REQ-009 Port pix_valid, output, 1: the pixel on pix_row, pix_col and pix_on is valid.
REQ-010 Port pix_ready, input, 1: the downstream matrix writer accepts the pixel.
REQ-011 Port pix_row, output, 4: matrix row, equal to Y_OFF + glyph row.
REQ-012 Port pix_col, output, 5: matrix column, equal to X_OFF + glyph column.
REQ-013 Port pix_on, output, 1: 1 means the LED is lit.
REQ-014 Port glyph_done, output, 1: one-cycle pulse when the glyph is complete.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-016 digit_ready SHALL be 1 only in IDLE.
REQ-017 A digit SHALL be accepted on the cycle when digit_valid and digit_ready are both 1.
REQ-018 On acceptance, the block SHALL latch digit, set glyph row and glyph column to 0, and enter SCAN on the next edge.
REQ-019 In SCAN, pix_valid SHALL be 1; in IDLE and DONE, pix_valid SHALL be 0.
REQ-020 Pixel scan order SHALL be raster order: row 0..6, and within each row column 0..4, giving 35 pixels per glyph.
REQ-021 The pixel position SHALL advance only on the cycle when pix_valid and pix_ready are both 1.
REQ-022 While pix_valid=1 and pix_ready=0, pix_row, pix_col and pix_on SHALL hold stable.
REQ-023 Column wrap: when column 4 is accepted, the column SHALL return to 0 and the row SHALL increment by 1.
REQ-024 When row 6, column 4 is accepted, the FSM SHALL enter DONE.
REQ-025 In DONE, glyph_done SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-026 digit_valid and digit SHALL be ignored in SCAN and DONE; no digit is queued.
REQ-027 pix_on SHALL equal bit (4 - col) of the font row byte for the latched digit and the current row.
REQ-028 The font table SHALL be as follows (rows 0..6, hex):
0=0E,11,13,15,19,11,0E; 1=04,0C,04,04,04,04,0E; 2=0E,11,01,02,04,08,1F;
3=1F,02,04,02,01,11,0E; 4=02,06,0A,12,1F,02,02; 5=1F,10,1E,01,01,11,0E;
6=06,08,10,1E,11,11,0E; 7=1F,01,02,04,08,08,08; 8=0E,11,11,0E,11,11,0E;
9=0E,11,11,0F,01,02,0C.
REQ-029 For latched digit values 10..15, the block SHALL still scan all 35 pixels, with pix_on=0 for every pixel.
REQ-030 pix_row and pix_col arithmetic SHALL be unsigned and SHALL have no overflow for legal parameter values.
REQ-031 Latency with pix_ready held at 1: accept at cycle T; pixels on T+1..T+35; glyph_done at T+36; digit_ready=1 at T+37.
REQ-032 pix_ready=1 outside SCAN SHALL have no effect.

Reset
REQ-033 While rst=0, the FSM SHALL be in IDLE, with row=0, col=0 and latched digit=0.
REQ-034 While rst=0, outputs SHALL be: digit_ready=1, pix_valid=0, glyph_done=0, pix_on=0, pix_row=Y_OFF, pix_col=X_OFF.
REQ-035 Reset asserted during SCAN or DONE SHALL abort the glyph immediately with no glyph_done pulse.
REQ-036 After rst deasserts, the first rising edge SHALL be able to accept a digit.

Verification
REQ-037 Scenario 1: digit=0, X_OFF=0, Y_OFF=0, pix_ready=1 -> 35 pixels. Row 0 pix_on = 0,1,1,1,0; row 2 pix_on = 1,0,0,1,1. glyph_done at T+36.
REQ-038 Scenario 2: digit=8, X_OFF=27, Y_OFF=9 -> pix_col spans 27..31 and pix_row spans 9..15; the last pixel is (15,31) with pix_on=0.
REQ-039 Scenario 3: digit=1 with pix_ready low for 3 cycles at pixel (0,2) -> pix_on=1 is held stable for those 3 cycles, and all 35 pixels appear with no skip or duplicate.
REQ-040 Scenario 4: digit=12 -> 35 pixels, all with pix_on=0, then glyph_done.
REQ-041 Scenario 5: digit_valid held high with digit=5 during a scan of digit 3 -> digit 5 is accepted only at T+37 and rendered next; row 0 = 1,1,1,1,1.
REQ-042 Scenario 6: rst=0 asynchronously at pixel 20 -> pix_valid=0 immediately and digit_ready=1; no glyph_done; a following digit=7 scans from pixel (0,0).

Source files
------------

// File: rtl/digit_glyph_rd.sv
// digit_glyph_rd: renders one BCD digit as a 5x7 glyph, streaming one pixel per
// handshake in raster order to a downstream LED matrix writer at (X_OFF, Y_OFF).
module digit_glyph_rd #(
    parameter int unsigned X_OFF = 0,
    parameter int unsigned Y_OFF = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    output logic       digit_ready,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic [3:0] pix_row,
    output logic [4:0] pix_col,
    output logic       pix_on,
    output logic       glyph_done
);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_t;

    localparam logic [2:0] LastRow = 3'd6;
    localparam logic [2:0] LastCol = 3'd4;

    state_t     r_state;
    logic [3:0] r_digit;
    logic [2:0] r_row;
    logic [2:0] r_col;
    logic       r_ready;
    logic       r_pix_valid;
    logic       r_done;

    logic [4:0] w_font_row;
    logic [2:0] w_bit_idx;

    // 5-bit font row for a digit; the leftmost glyph column is the MSB.
    // Non-BCD codes render blank.
    function automatic logic [4:0] font_row(input logic [3:0] d, input logic [2:0] r);
        logic [34:0] glyph;
        logic [4:0]  row_bits;
        unique case (d)
            4'd0:    glyph = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
            4'd1:    glyph = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
            4'd2:    glyph = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
            4'd3:    glyph = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
            4'd4:    glyph = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
            4'd5:    glyph = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
            4'd6:    glyph = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
            4'd7:    glyph = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
            4'd8:    glyph = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
            4'd9:    glyph = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
            default: glyph = '0;
        endcase
        unique case (r)
            3'd0:    row_bits = glyph[34:30];
            3'd1:    row_bits = glyph[29:25];
            3'd2:    row_bits = glyph[24:20];
            3'd3:    row_bits = glyph[19:15];
            3'd4:    row_bits = glyph[14:10];
            3'd5:    row_bits = glyph[9:5];
            3'd6:    row_bits = glyph[4:0];
            default: row_bits = '0;
        endcase
        return row_bits;
    endfunction

    // Pixel value looked up from the latched digit and current scan position.
    always_comb begin
        w_font_row = font_row(r_digit, r_row);
        w_bit_idx  = LastCol - r_col;
    end

    assign pix_on      = w_font_row[w_bit_idx];
    assign pix_row     = 4'(Y_OFF) + 4'(r_row);
    assign pix_col     = 5'(X_OFF) + 5'(r_col);
    assign digit_ready = r_ready;
    assign pix_valid   = r_pix_valid;
    assign glyph_done  = r_done;

    // Control FSM: accept a digit, raster-scan 35 pixels, pulse done, return to idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_digit     <= 4'd0;
            r_row       <= 3'd0;
            r_col       <= 3'd0;
            r_ready     <= 1'b1;
            r_pix_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (digit_valid) begin
                        r_digit     <= digit;
                        r_row       <= 3'd0;
                        r_col       <= 3'd0;
                        r_ready     <= 1'b0;
                        r_pix_valid <= 1'b1;
                        r_state     <= StScan;
                    end
                end
                StScan: begin
                    // Position moves only when the writer takes the pixel.
                    if (pix_ready) begin
                        if (r_col == LastCol) begin
                            r_col <= 3'd0;
                            if (r_row == LastRow) begin
                                r_row       <= 3'd0;
                                r_pix_valid <= 1'b0;
                                r_done      <= 1'b1;
                                r_state     <= StDone;
                            end else begin
                                r_row <= r_row + 3'd1;
                            end
                        end else begin
                            r_col <= r_col + 3'd1;
                        end
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= StIdle;
                end
                default: begin
                    r_ready     <= 1'b1;
                    r_pix_valid <= 1'b0;
                    r_done      <= 1'b0;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

endmodule
